// File: rtl/line_writeback_buffer_if.sv
// rtl/line_writeback_buffer_if.sv - cache-side and memory-side signals of the line write-back buffer
interface line_writeback_buffer_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int LINE_WIDTH    = 128
);
  logic                     Cache_WE;
  logic [ADDRESS_WIDTH-1:0] Cache_write_address;
  logic [LINE_WIDTH-1:0]    Cache_bus_in;
  logic [ADDRESS_WIDTH-1:0] Cache_read_address;
  logic [LINE_WIDTH-1:0]    Cache_bus_out;
  logic                     Buffer_full;
  logic                     Fwd_hit;
  logic                     Memory_WE;
  logic [ADDRESS_WIDTH-1:0] Memory_write_address;
  logic [LINE_WIDTH-1:0]    Memory_bus_out;
  logic                     Memory_ready;
  logic [ADDRESS_WIDTH-1:0] Memory_read_address;
  logic [LINE_WIDTH-1:0]    Memory_bus_in;

  modport slave (
    input  Cache_WE, Cache_write_address, Cache_bus_in, Cache_read_address,
           Memory_ready, Memory_bus_in,
    output Cache_bus_out, Buffer_full, Fwd_hit, Memory_WE, Memory_write_address,
           Memory_bus_out, Memory_read_address
  );

  modport master (
    output Cache_WE, Cache_write_address, Cache_bus_in, Cache_read_address,
           Memory_ready, Memory_bus_in,
    input  Cache_bus_out, Buffer_full, Fwd_hit, Memory_WE, Memory_write_address,
           Memory_bus_out, Memory_read_address
  );
endinterface

// File: rtl/line_writeback_buffer.sv
// rtl/line_writeback_buffer.sv - posted line write-back FIFO with read forwarding
// Optional in-place coalescing of same-line pushes: WB_COALESCE_EN.
module line_writeback_buffer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int LINE_WIDTH    = 128,
  parameter int DEPTH         = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  line_writeback_buffer_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam int TAG_W = ADDRESS_WIDTH - OFF_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic                  valid_q [DEPTH];
  logic [TAG_W-1:0]      tag_q   [DEPTH];
  logic [LINE_WIDTH-1:0] data_q  [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [TAG_W-1:0]      wr_tag;
  logic [TAG_W-1:0]      rd_tag;
  logic                  full;
  logic                  pop;
  logic                  push_alloc;
  logic                  coal_hit;
  logic                  fwd_hit;
  logic [LINE_WIDTH-1:0] fwd_data;
  logic [PTR_W-1:0]      fwd_idx;
  logic                  unused_offsets;

  assign wr_tag         = bus.Cache_write_address[ADDRESS_WIDTH-1:OFF_W];
  assign rd_tag         = bus.Cache_read_address[ADDRESS_WIDTH-1:OFF_W];
  assign unused_offsets = ^bus.Cache_write_address[OFF_W-1:0];

  assign full       = (count_q == FULL_CNT);
  assign pop        = (count_q != '0) && bus.Memory_ready;
  assign push_alloc = bus.Cache_WE && !full && !coal_hit;

`ifdef WB_COALESCE_EN
  logic [PTR_W-1:0] coal_idx;
  logic [PTR_W-1:0] coal_scan;

  // The head leaving this cycle cannot absorb new data; it must go out as-is.
  always_comb begin
    coal_hit  = 1'b0;
    coal_idx  = '0;
    coal_scan = '0;
    for (int i = 0; i < DEPTH; i++) begin
      coal_scan = head_q + PTR_W'(i);
      if (bus.Cache_WE && valid_q[coal_scan] && (tag_q[coal_scan] == wr_tag) &&
          !(pop && (coal_scan == head_q))) begin
        coal_hit = 1'b1;
        coal_idx = coal_scan;
      end
    end
  end
`else
  assign coal_hit = 1'b0;
`endif

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)        head_d = head_q + PTR_W'(1);
    if (push_alloc) tail_d = tail_q + PTR_W'(1);
    if (push_alloc && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push_alloc && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (pop)        valid_q[head_q] <= 1'b0;
      if (push_alloc) valid_q[tail_q] <= 1'b1;
    end
  end

  // Payload needs no reset: valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (push_alloc) begin
      tag_q[tail_q]  <= wr_tag;
      data_q[tail_q] <= bus.Cache_bus_in;
    end
`ifdef WB_COALESCE_EN
    if (coal_hit) data_q[coal_idx] <= bus.Cache_bus_in;
`endif
  end

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = bus.Memory_bus_in;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if (valid_q[fwd_idx] && (tag_q[fwd_idx] == rd_tag)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  assign bus.Cache_bus_out        = fwd_data;
  assign bus.Fwd_hit              = fwd_hit;
  assign bus.Buffer_full          = full;
  assign bus.Memory_WE            = (count_q != '0);
  assign bus.Memory_write_address = {tag_q[head_q], {OFF_W{1'b0}}};
  assign bus.Memory_bus_out       = data_q[head_q];
  assign bus.Memory_read_address  = bus.Cache_read_address;
endmodule

// File: tb/tb_line_writeback_buffer.sv
// tb/tb_line_writeback_buffer.sv - directed self-checking bench for line_writeback_buffer
module tb_line_writeback_buffer;
  localparam logic [127:0] MEM_PAT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  line_writeback_buffer_if bus ();

  line_writeback_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] line(input logic [3:0] nib);
    return {32{nib}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.Cache_WE = 1'b0;
    bus.Cache_write_address = '0;
    bus.Cache_bus_in = '0;
    bus.Cache_read_address = 32'h100;
    bus.Memory_ready = 1'b0;
    bus.Memory_bus_in = MEM_PAT;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (bus.Memory_WE !== 1'b0) begin bad++; $display("FAIL reset_memory_we got=%0h want=0", bus.Memory_WE); end
    total++; if (bus.Buffer_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0h want=0", bus.Buffer_full); end
    total++; if (bus.Fwd_hit !== 1'b0) begin bad++; $display("FAIL reset_fwd_hit got=%0h want=0", bus.Fwd_hit); end
    total++; if (bus.Cache_bus_out !== MEM_PAT) begin bad++; $display("FAIL reset_bus_out got=%h want=%h", bus.Cache_bus_out, MEM_PAT); end
    total++; if (bus.Memory_read_address !== 32'h100) begin bad++; $display("FAIL read_passthru got=%h want=%h", bus.Memory_read_address, 32'h100); end
  endtask

  task automatic test_fill_and_drain();
    bus.Memory_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.Cache_WE = 1'b1;
      bus.Cache_write_address = 32'((i + 1) * 256);
      bus.Cache_bus_in = line(4'(10 + i));
      tick();
      total++; if (bus.Buffer_full !== (i == 3)) begin bad++; $display("FAIL fill_full[%0d] got=%0h want=%0h", i, bus.Buffer_full, (i == 3)); end
      if (i == 0) begin
        total++; if (bus.Memory_WE !== 1'b1) begin bad++; $display("FAIL first_push_we got=%0h want=1", bus.Memory_WE); end
        total++; if (bus.Memory_write_address !== 32'h100) begin bad++; $display("FAIL first_push_addr got=%h want=%h", bus.Memory_write_address, 32'h100); end
      end
    end
    // Push while full: protocol violation, must be dropped.
    bus.Cache_write_address = 32'h500;
    bus.Cache_bus_in = line(4'hE);
    tick();
    bus.Cache_WE = 1'b0;
    #1;
    total++; if (bus.Buffer_full !== 1'b1) begin bad++; $display("FAIL full_after_drop got=%0h want=1", bus.Buffer_full); end
    total++; if (bus.Memory_write_address !== 32'h100) begin bad++; $display("FAIL hold_addr got=%h want=%h", bus.Memory_write_address, 32'h100); end
    total++; if (bus.Memory_bus_out !== line(4'hA)) begin bad++; $display("FAIL hold_data got=%h want=%h", bus.Memory_bus_out, line(4'hA)); end
    for (int i = 0; i < 4; i++) begin
      bus.Memory_ready = 1'b1;
      bus.Cache_WE = (i == 0);
      bus.Cache_write_address = 32'h600;
      bus.Cache_bus_in = line(4'hF);
      #1;
      total++; if (bus.Memory_WE !== 1'b1) begin bad++; $display("FAIL drain_we[%0d] got=%0h want=1", i, bus.Memory_WE); end
      total++; if (bus.Memory_write_address !== 32'((i + 1) * 256)) begin bad++; $display("FAIL drain_addr[%0d] got=%h want=%h", i, bus.Memory_write_address, 32'((i + 1) * 256)); end
      total++; if (bus.Memory_bus_out !== line(4'(10 + i))) begin bad++; $display("FAIL drain_data[%0d] got=%h want=%h", i, bus.Memory_bus_out, line(4'(10 + i))); end
      tick();
      bus.Cache_WE = 1'b0;
      total++; if (bus.Buffer_full !== 1'b0) begin bad++; $display("FAIL drain_full[%0d] got=%0h want=0", i, bus.Buffer_full); end
    end
    #1;
    total++; if (bus.Memory_WE !== 1'b0) begin bad++; $display("FAIL drain_empty_we got=%0h want=0", bus.Memory_WE); end
    bus.Memory_ready = 1'b0;
  endtask

  task automatic test_forward();
    bus.Memory_ready = 1'b0;
    bus.Cache_WE = 1'b1;
    bus.Cache_write_address = 32'h200;
    bus.Cache_bus_in = line(4'hB);
    bus.Cache_read_address = 32'h204;
    #1;
    total++; if (bus.Fwd_hit !== 1'b0) begin bad++; $display("FAIL fwd_same_cycle got=%0h want=0", bus.Fwd_hit); end
    total++; if (bus.Cache_bus_out !== MEM_PAT) begin bad++; $display("FAIL fwd_same_cycle_data got=%h want=%h", bus.Cache_bus_out, MEM_PAT); end
    tick();
    bus.Cache_WE = 1'b0;
    #1;
    total++; if (bus.Fwd_hit !== 1'b1) begin bad++; $display("FAIL fwd_hit got=%0h want=1", bus.Fwd_hit); end
    total++; if (bus.Cache_bus_out !== line(4'hB)) begin bad++; $display("FAIL fwd_data got=%h want=%h", bus.Cache_bus_out, line(4'hB)); end
    bus.Memory_ready = 1'b1;
    #1;
    total++; if (bus.Fwd_hit !== 1'b1) begin bad++; $display("FAIL fwd_while_pop got=%0h want=1", bus.Fwd_hit); end
    tick();
    bus.Memory_ready = 1'b0;
    #1;
    total++; if (bus.Fwd_hit !== 1'b0) begin bad++; $display("FAIL fwd_after_drain got=%0h want=0", bus.Fwd_hit); end
    total++; if (bus.Cache_bus_out !== MEM_PAT) begin bad++; $display("FAIL fwd_after_drain_data got=%h want=%h", bus.Cache_bus_out, MEM_PAT); end
  endtask

  task automatic test_back_to_back();
    logic we_t [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic rd_t [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int cnt = 0;
    int np  = 0;
    int nd  = 0;
    int pushed;
    int popped;
    for (int c = 0; c < 12; c++) begin
      bus.Cache_WE = we_t[c];
      bus.Cache_write_address = 32'h1000 + 32'(np * 256);
      bus.Cache_bus_in = line(4'(np + 1));
      bus.Memory_ready = rd_t[c];
      #1;
      total++; if (bus.Memory_WE !== (cnt != 0)) begin bad++; $display("FAIL b2b_we[%0d] got=%0h want=%0h", c, bus.Memory_WE, (cnt != 0)); end
      popped = 0;
      if (rd_t[c] && cnt != 0) begin
        total++; if (bus.Memory_write_address !== 32'h1000 + 32'(nd * 256)) begin bad++; $display("FAIL b2b_addr[%0d] got=%h want=%h", c, bus.Memory_write_address, 32'h1000 + 32'(nd * 256)); end
        total++; if (bus.Memory_bus_out !== line(4'(nd + 1))) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", c, bus.Memory_bus_out, line(4'(nd + 1))); end
        nd++;
        popped = 1;
      end
      pushed = (we_t[c] && cnt != 4) ? 1 : 0;
      tick();
      np  += pushed;
      cnt += pushed - popped;
      total++; if (bus.Buffer_full !== (cnt == 4)) begin bad++; $display("FAIL b2b_full[%0d] got=%0h want=%0h", c, bus.Buffer_full, (cnt == 4)); end
    end
    bus.Cache_WE = 1'b0;
    bus.Memory_ready = 1'b0;
    #1;
    total++; if (bus.Memory_WE !== 1'b0) begin bad++; $display("FAIL b2b_end_we got=%0h want=0", bus.Memory_WE); end
  endtask

  task automatic test_duplicate_line();
    bus.Memory_ready = 1'b0;
    bus.Cache_WE = 1'b1;
    bus.Cache_write_address = 32'h100;
    bus.Cache_bus_in = line(4'h1);
    tick();
    bus.Cache_bus_in = line(4'h2);
    tick();
    bus.Cache_WE = 1'b0;
    bus.Cache_read_address = 32'h100;
    #1;
    total++; if (bus.Fwd_hit !== 1'b1) begin bad++; $display("FAIL dup_fwd_hit got=%0h want=1", bus.Fwd_hit); end
    total++; if (bus.Cache_bus_out !== line(4'h2)) begin bad++; $display("FAIL dup_fwd_data got=%h want=%h", bus.Cache_bus_out, line(4'h2)); end
`ifdef WB_COALESCE_EN
    total++; if (bus.Memory_bus_out !== line(4'h2)) begin bad++; $display("FAIL coal_head_data got=%h want=%h", bus.Memory_bus_out, line(4'h2)); end
    bus.Memory_ready = 1'b1;
    tick();
    total++; if (bus.Memory_WE !== 1'b0) begin bad++; $display("FAIL coal_single_drain got=%0h want=0", bus.Memory_WE); end
`else
    total++; if (bus.Memory_bus_out !== line(4'h1)) begin bad++; $display("FAIL dup_first_data got=%h want=%h", bus.Memory_bus_out, line(4'h1)); end
    bus.Memory_ready = 1'b1;
    tick();
    total++; if (bus.Memory_WE !== 1'b1) begin bad++; $display("FAIL dup_second_we got=%0h want=1", bus.Memory_WE); end
    total++; if (bus.Memory_bus_out !== line(4'h2)) begin bad++; $display("FAIL dup_second_data got=%h want=%h", bus.Memory_bus_out, line(4'h2)); end
    tick();
    total++; if (bus.Memory_WE !== 1'b0) begin bad++; $display("FAIL dup_end_we got=%0h want=0", bus.Memory_WE); end
`endif
    bus.Memory_ready = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    bus.Memory_ready = 1'b0;
    bus.Cache_WE = 1'b1;
    bus.Cache_write_address = 32'h700;
    bus.Cache_bus_in = line(4'h7);
    tick();
    bus.Cache_write_address = 32'h800;
    bus.Cache_bus_in = line(4'h8);
    tick();
    bus.Cache_WE = 1'b0;
    #1;
    total++; if (bus.Memory_WE !== 1'b1) begin bad++; $display("FAIL pre_reset_we got=%0h want=1", bus.Memory_WE); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    total++; if (bus.Memory_WE !== 1'b0) begin bad++; $display("FAIL mid_reset_we got=%0h want=0", bus.Memory_WE); end
    total++; if (bus.Buffer_full !== 1'b0) begin bad++; $display("FAIL mid_reset_full got=%0h want=0", bus.Buffer_full); end
    bus.Cache_read_address = 32'h700;
    #1;
    total++; if (bus.Fwd_hit !== 1'b0) begin bad++; $display("FAIL mid_reset_fwd700 got=%0h want=0", bus.Fwd_hit); end
    bus.Cache_read_address = 32'h800;
    #1;
    total++; if (bus.Fwd_hit !== 1'b0) begin bad++; $display("FAIL mid_reset_fwd800 got=%0h want=0", bus.Fwd_hit); end
    bus.Memory_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.Memory_WE !== 1'b0) begin bad++; $display("FAIL post_reset_we[%0d] got=%0h want=0", i, bus.Memory_WE); end
    end
    bus.Memory_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fill_and_drain();
    test_forward();
    test_back_to_back();
    test_duplicate_line();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/line_writeback_buffer.md
# line_writeback_buffer

Posted-write buffer between the data cache's line-eviction port and the line-wide data RAM. Evicted 128-bit lines are pushed in one cycle and drained to memory in FIFO order whenever the memory accepts a write. This lets the cache refill without waiting for the write-back. Line reads from the cache pass through to memory, with data from any still-pending buffered line forwarded in their place so the cache never sees stale memory contents.

## Interface
- ADDRESS_WIDTH, 32, byte address width
- LINE_WIDTH, 128, line width in bits (4 words; line offset = address[3:0])
- DEPTH, 4, buffer entries (power of two, ≥2)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- Cache_WE  in  1  push evicted line
- Cache_write_address  in  ADDRESS_WIDTH  evicted line address
- Cache_bus_in  in  LINE_WIDTH  evicted line data
- Cache_read_address  in  ADDRESS_WIDTH  refill line address
- Cache_bus_out  out  LINE_WIDTH  refill data (forwarded or memory)
- Buffer_full  out  1  no free entry; cache must stall evictions
- Fwd_hit  out  1  Cache_bus_out sourced from buffer
- Memory_WE  out  1  drain request valid
- Memory_write_address  out  ADDRESS_WIDTH  head entry address, offset bits forced 0
- Memory_bus_out  out  LINE_WIDTH  head entry data
- Memory_ready  in  1  memory accepts write this cycle
- Memory_read_address  out  ADDRESS_WIDTH  = Cache_read_address, pass-through
- Memory_bus_in  in  LINE_WIDTH  memory read data

## Operation
- Storage: DEPTH entries {valid, tag = address[ADDRESS_WIDTH-1:4], data}.
- Head/tail pointers wrap modulo DEPTH; count is 0..DEPTH.
- Push: on Cache_WE && !Buffer_full, the line is written at tail, tail++, count++.
- Push while Buffer_full is dropped and state is unchanged. This is a cache protocol violation, and the bench flags it.
- Drain: Memory_WE = (count != 0). Address and data come from head.
- On Memory_WE && Memory_ready: head entry invalidated, head++, count--.
- Simultaneous push and pop: both occur and count is unchanged.
  - Push at count==DEPTH with a pop in the same cycle is still dropped, because Buffer_full depends on count only.
- Forwarding (combinational): compare the tag of Cache_read_address against all valid entries.
  - The youngest match (closest to tail) drives Cache_bus_out, with Fwd_hit=1.
  - If there is no match, Cache_bus_out = Memory_bus_in and Fwd_hit=0.
  - The head entry being popped this cycle still forwards this cycle.
- Forwarding uses stored entries only. A line pushed in cycle N is not forwarded in cycle N.
- Buffer_full = (count == DEPTH).

## Timing
- Reset (rst_n low at a clock edge):
  - count, head and tail = 0; all valid = 0.
  - Memory_WE=0, Buffer_full=0, Fwd_hit=0.
  - Pending lines are discarded, including on reset mid-drain.
- Push latency: a line pushed at edge N is presented on the memory port from edge N onward, so Memory_WE is high in cycle N+1 if the buffer was empty.
- Memory handshake: Memory_WE, address and data hold stable until Memory_ready is sampled high. Throughput is 1 line/cycle with Memory_ready held high.
- Forward path is combinational from Cache_read_address to Cache_bus_out/Fwd_hit, with no added latency over memory read.
- Buffer_full rises the cycle after the push that fills the last entry. It falls the cycle after the first pop.

## Configuration
- WB_COALESCE_EN defined:
  - A push whose tag matches a valid entry that is not being popped this cycle overwrites that entry's data in place. Count and tail are unchanged.
  - This is accepted even when Buffer_full=1.
  - If the only match is the head being popped this cycle, a new entry is allocated instead. This is subject to Buffer_full.
- WB_COALESCE_EN undefined: every push allocates a new entry, so duplicate tags may coexist. Forwarding picks the youngest; the drain writes both, oldest first.

## Test plan
- Reset then idle → Memory_WE=0, Buffer_full=0, Fwd_hit=0; Cache_bus_out equals Memory_bus_in for read address 0x100.
- Memory_ready=0; push 0x100, 0x200, 0x300, 0x400 (data 0xA…, 0xB…, 0xC…, 0xD…) → Buffer_full=1 after the 4th. A 5th push to 0x500 is dropped. Raising Memory_ready drains 0x100..0x400 in order over 4 cycles.
- Line 0x200 buffered with 0xB…, then read 0x204 → Fwd_hit=1, Cache_bus_out=0xB…. After its drain completes, reading 0x204 returns Memory_bus_in.
- Buffer holds 3 entries; push and pop in the same cycle → count stays 3. Drain order is preserved across pointer wrap (8 pushes total).
- Push 0x100=0x11…, then 0x100=0x22… with Memory_ready=0:
  - With WB_COALESCE_EN: one entry holds 0x22…, and one drain occurs.
  - Without it: two entries exist, the forward returns 0x22…, and the drains write 0x11… then 0x22….
- Two lines pending and Memory_WE high; assert rst_n=0 for one cycle → next cycle Memory_WE=0 and Fwd_hit=0 for both addresses; no further writes issued.
